// File: rtl/prog_counter_pkg.sv
// Shared constants for the programmable up/down counter: saturation mode and
// count direction encodings.
package prog_counter_pkg;
  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
endpackage

// File: rtl/prog_counter_step_adder.sv
// Combinational WIDTH+1-bit add/subtract; bit WIDTH is carry-out (up) or
// borrow (down).
module step_adder
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             up_dn,
  output logic [WIDTH:0]   sum
);
  always_comb begin
    if (up_dn == DIR_UP) sum = {1'b0, a} + {1'b0, b};
    else                 sum = {1'b0, a} - {1'b0, b};
  end
endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with load, variable step, and wrap or
// saturate behaviour on carry/borrow; ovf flags the event for one cycle.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum;

  step_adder #(.WIDTH(WIDTH)) u_step_adder (
    .a     (count_q),
    .b     (step),
    .up_dn (up_dn),
    .sum   (sum)
  );

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (sum[WIDTH]) begin
        ovf_d = 1'b1;
        // Saturation pins to the limit in the direction of travel.
        if (SATURATE == MODE_SAT)
          count_d = (up_dn == DIR_UP) ? {WIDTH{1'b1}} : '0;
        else
          count_d = sum[WIDTH-1:0];
      end else begin
        count_d = sum[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count  = count_q;
  assign ovf    = ovf_q;
  assign at_max = (count_q == {WIDTH{1'b1}});
  assign at_min = (count_q == '0);
endmodule

// File: tb/tb_prog_counter.sv
// Directed bench: one wrapping and one saturating WIDTH=4 counter driven by
// the same vectors, each checked against hand-computed expectations.
module tb_prog_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, load, up_dn;
  logic [W-1:0] load_val, step;
  logic [W-1:0] cnt_w, cnt_s;
  logic         ovf_w, ovf_s, max_w, max_s, min_w, min_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prog_counter #(.WIDTH(W), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .step(step), .count(cnt_w), .ovf(ovf_w),
    .at_max(max_w), .at_min(min_w)
  );

  prog_counter #(.WIDTH(W), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .step(step), .count(cnt_s), .ovf(ovf_s),
    .at_max(max_s), .at_min(min_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic ld, input logic [W-1:0] lv,
                     input logic e, input logic ud, input logic [W-1:0] st);
    rst = r; load = ld; load_val = lv; en = e; up_dn = ud; step = st;
    @(posedge clk);
    #1;
  endtask

  task automatic expect4(input string tag, input int cw, input int ow, input int cs, input int os);
    chk({tag, ".wrap.count"}, 32'(cnt_w), 32'(cw));
    chk({tag, ".wrap.ovf"},   32'(ovf_w), 32'(ow));
    chk({tag, ".wrap.max"},   32'(max_w), 32'(cw == 15));
    chk({tag, ".wrap.min"},   32'(min_w), 32'(cw == 0));
    chk({tag, ".sat.count"},  32'(cnt_s), 32'(cs));
    chk({tag, ".sat.ovf"},    32'(ovf_s), 32'(os));
    chk({tag, ".sat.max"},    32'(max_s), 32'(cs == 15));
    chk({tag, ".sat.min"},    32'(min_s), 32'(cs == 0));
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1; step = '0;
    @(negedge clk);

    // Reset overrides load and enable
    cyc(1, 1, 9, 1, 1, 1);        expect4("reset",       0, 0,  0, 0);

    // Wrap / clamp going up from 15
    cyc(0, 1, 15, 0, 1, 0);       expect4("load15",     15, 0, 15, 0);
    cyc(0, 0, 0, 1, 1, 1);        expect4("up_evt",      0, 1, 15, 1);
    cyc(0, 0, 0, 1, 1, 1);        expect4("up_next",     1, 0, 15, 1);

    // Borrow going down from 2 by 3
    cyc(0, 1, 2, 0, 0, 0);        expect4("load2",       2, 0,  2, 0);
    cyc(0, 0, 0, 1, 0, 3);        expect4("dn_evt",     15, 1,  0, 1);
    cyc(0, 0, 0, 1, 0, 3);        expect4("dn_again",   12, 0,  0, 1);

    // Load beats enable
    cyc(0, 1, 7, 1, 1, 5);        expect4("prio",        7, 0,  7, 0);

    // Hold clears a pending ovf, then holds count
    cyc(0, 1, 15, 0, 1, 0);       expect4("load15b",    15, 0, 15, 0);
    cyc(0, 0, 0, 1, 1, 1);        expect4("up_evt2",     0, 1, 15, 1);
    cyc(0, 0, 0, 0, 1, 1);        expect4("hold_clr",    0, 0, 15, 0);

    cyc(0, 1, 6, 0, 1, 0);        expect4("load6",       6, 0,  6, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 4);      expect4("hold",        6, 0,  6, 0);
    end
    cyc(0, 0, 0, 1, 1, 0);        expect4("step0",       6, 0,  6, 0);

    // Mid-run reset then resume
    cyc(0, 1, 11, 0, 1, 0);       expect4("load11",     11, 0, 11, 0);
    cyc(0, 0, 0, 1, 1, 1);        expect4("run12",      12, 0, 12, 0);
    cyc(1, 0, 0, 1, 1, 1);        expect4("midrst",      0, 0,  0, 0);
    cyc(0, 0, 0, 1, 1, 2);        expect4("resume",      2, 0,  2, 0);

    // Direction flip takes effect on the same edge
    cyc(0, 0, 0, 1, 0, 1);        expect4("flip_dn",     1, 0,  1, 0);
    cyc(0, 0, 0, 1, 1, 13);       expect4("big_up",     14, 0, 14, 0);
    cyc(0, 0, 0, 1, 1, 1);        expect4("to_max",     15, 0, 15, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
